bus_arbiter: RTL and testbench

Parametrised multi-port bus arbiter with a wait-state handshake, placed between the core's memory requestors and the single system bus. Its requestors are typically instruction fetch, data memory interface and debug/DMA. It grants one port at a time using round-robin order. It forwards the latched request to the bus and holds it until the bus signals `bus_ready`. It then returns a one-cycle `port_ready` pulse, plus read data, to the granted port. An optional watchdog aborts bus transactions that never complete.

---
 rtl/bus_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin multi-port bus arbiter with wait-state handshake
// Optional watchdog abort enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_write_data,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_byte_enable,
    input  logic [NUM_PORTS-1:0]              port_read_enable,
    input  logic [NUM_PORTS-1:0]              port_write_enable,
    output logic [NUM_PORTS-1:0]              port_ready,
    output logic [NUM_PORTS-1:0]              port_error,
    output logic [DATA_WIDTH-1:0]             port_read_data,
    output logic [ADDR_WIDTH-1:0]             bus_address,
    output logic [DATA_WIDTH-1:0]             bus_write_data,
    output logic [DATA_WIDTH/8-1:0]           bus_byte_enable,
    output logic                              bus_read_enable,
    output logic                              bus_write_enable,
    input  logic                              bus_ready,
    input  logic [DATA_WIDTH-1:0]             bus_read_data
);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                 state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          winner;
    logic                   req_any;
    logic [NUM_PORTS-1:0]   port_req;
    logic [NUM_PORTS-1:0]   ready_q;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   winner_write;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          timer;
    logic [NUM_PORTS-1:0]   error_q;
    assign port_error = error_q;
`else
    assign port_error = '0;
`endif

    assign port_req       = port_read_enable | port_write_enable;
    assign port_ready     = ready_q;
    assign port_read_data = rd_data;
    assign winner_write   = port_write_enable[winner];

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = last_grant;
        req_any = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!req_any && port_req[idx]) begin
                req_any = 1'b1;
                winner  = GW'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            grant            <= '0;
            last_grant       <= GW'(NUM_PORTS - 1);
            ready_q          <= '0;
            rd_data          <= '0;
            bus_address      <= '0;
            bus_write_data   <= '0;
            bus_byte_enable  <= '0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            timer            <= '0;
            error_q          <= '0;
`endif
        end else begin
            ready_q <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            error_q <= '0;
`endif
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant            <= winner;
                        last_grant       <= winner;
                        bus_address      <= port_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        bus_write_data   <= port_write_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        bus_byte_enable  <= port_byte_enable[int'(winner)*BW +: BW];
                        bus_write_enable <= winner_write;
                        bus_read_enable  <= ~winner_write;
                        state            <= ACCESS;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        timer            <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // bus_ready is checked first so a completion on the limit cycle is not an error.
                    if (bus_ready) begin
                        rd_data          <= bus_write_enable ? '0 : bus_read_data;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        ready_q[grant]   <= 1'b1;
                        state            <= RESPOND;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        rd_data          <= '0;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        ready_q[grant]   <= 1'b1;
                        error_q[grant]   <= 1'b1;
                        state            <= RESPOND;
                    end else begin
                        timer <= timer + TW'(1);
                    end
`endif
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (2 ports, 32-bit)
module tb_bus_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clock;
    logic              reset;
    logic [N*AW-1:0]   port_address;
    logic [N*DW-1:0]   port_write_data;
    logic [N*DW/8-1:0] port_byte_enable;
    logic [N-1:0]      port_read_enable;
    logic [N-1:0]      port_write_enable;
    logic [N-1:0]      port_ready;
    logic [N-1:0]      port_error;
    logic [DW-1:0]     port_read_data;
    logic [AW-1:0]     bus_address;
    logic [DW-1:0]     bus_write_data;
    logic [DW/8-1:0]   bus_byte_enable;
    logic              bus_read_enable;
    logic              bus_write_enable;
    logic              bus_ready;
    logic [DW-1:0]     bus_read_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    bus_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .port_address(port_address), .port_write_data(port_write_data),
        .port_byte_enable(port_byte_enable), .port_read_enable(port_read_enable),
        .port_write_enable(port_write_enable), .port_ready(port_ready),
        .port_error(port_error), .port_read_data(port_read_data),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_ready(bus_ready),
        .bus_read_data(bus_read_data)
    );

    always #5 clock = ~clock;

    // Every completion pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (reset && port_ready !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected port_ready=%b", port_ready);
            end else begin
                e = sb.pop_front();
                if (port_ready !== (2'b01 << e.port) || port_read_data !== e.data ||
                    port_error !== (e.err ? (2'b01 << e.port) : 2'b00)) begin
                    errors++;
                    $display("FAIL sb_response got ready=%b err=%b data=%h want port=%0d err=%b data=%h",
                             port_ready, port_error, port_read_data, e.port, e.err, e.data);
                end
            end
        end
    end

    task automatic push_exp(input int p, input logic [31:0] d, input logic er);
        exp_t x;
        x.port = p; x.data = d; x.err = er;
        sb.push_back(x);
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic rd, input logic wr);
        port_address[p*AW +: AW]       = a;
        port_write_data[p*DW +: DW]    = d;
        port_byte_enable[p*4 +: 4]     = be;
        port_read_enable[p]            = rd;
        port_write_enable[p]           = wr;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable} !== '0 ||
            port_ready !== '0 || port_error !== '0 || port_read_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs addr=%h wd=%h be=%b re=%b we=%b rdy=%b err=%b rd=%h want all 0",
                     bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
                     port_ready, port_error, port_read_data);
        end
        reset = 1'b1;
    endtask

    task automatic test_read_zero_wait;
        int ren = 0;
        int wen = 0;
        @(negedge clock);
        set_req(0, 32'h0000_1000, 32'h0, 4'hF, 1'b1, 1'b0);
        bus_ready = 1'b1;
        bus_read_data = 32'hDEAD_BEEF;
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (bus_read_enable) ren++;
            if (bus_write_enable) wen++;
            if (c == 1) begin
                checks++;
                if (bus_address !== 32'h0000_1000) begin
                    errors++;
                    $display("FAIL rd_addr got %h want 00001000", bus_address);
                end
            end
            if (c == 2) begin
                checks++;
                if (port_ready !== 2'b01 || port_read_data !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL rd_cycle2 got ready=%b data=%h want 01 deadbeef", port_ready, port_read_data);
                end
                set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                bus_ready = 1'b0;
            end
        end
        checks++;
        if (ren != 1 || wen != 0) begin
            errors++;
            $display("FAIL rd_enable_cycles got re=%0d we=%0d want 1 0", ren, wen);
        end
    endtask

    task automatic test_write_wait;
        int wen = 0;
        int ren = 0;
        @(negedge clock);
        set_req(1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 1'b0, 1'b1);
        bus_ready = 1'b0;
        bus_read_data = 32'hFFFF_FFFF;
        push_exp(1, 32'h0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (bus_read_enable) ren++;
            if (bus_write_enable) begin
                wen++;
                checks++;
                if (bus_address !== 32'h20 || bus_write_data !== 32'h1234_5678 || bus_byte_enable !== 4'b0011) begin
                    errors++;
                    $display("FAIL wr_stable cycle %0d got a=%h d=%h be=%b", c, bus_address, bus_write_data, bus_byte_enable);
                end
            end
            if (c == 6) bus_ready = 1'b1;
            if (c == 7) begin
                checks++;
                if (port_ready !== 2'b10) begin
                    errors++;
                    $display("FAIL wr_ready_cycle7 got %b want 10", port_ready);
                end
                set_req(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                bus_ready = 1'b0;
            end
        end
        checks++;
        if (wen != 6 || ren != 0) begin
            errors++;
            $display("FAIL wr_enable_cycles got we=%0d re=%0d want 6 0", wen, ren);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] order [4];
        int n = 0;
        int last_c = 0;
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        @(negedge clock);
        set_req(0, 32'h0000_0100, 32'h0, 4'hF, 1'b1, 1'b0);
        set_req(1, 32'h0000_0200, 32'h0, 4'hF, 1'b1, 1'b0);
        bus_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            push_exp(k % 2, (k % 2 == 0 ? 32'h0000_0100 : 32'h0000_0200) ^ 32'h5A5A_0000, 1'b0);
        for (int c = 1; c <= 30 && n < 4; c++) begin
            @(negedge clock);
            bus_read_data = bus_address ^ 32'h5A5A_0000;
            if (port_ready !== 2'b00) begin
                checks++;
                if (port_ready !== order[n] || (n > 0 && c - last_c != 3)) begin
                    errors++;
                    $display("FAIL b2b_grant %0d got %b gap %0d want %b gap 3", n, port_ready, c - last_c, order[n]);
                end
                last_c = c;
                n++;
                if (n == 4) begin
                    set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                    set_req(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                    bus_ready = 1'b0;
                end
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", n);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_read_write_both;
        int wen = 0;
        int ren = 0;
        @(negedge clock);
        set_req(0, 32'h0000_0040, 32'hA5A5_0001, 4'hF, 1'b1, 1'b1);
        bus_ready = 1'b1;
        bus_read_data = 32'h1111_2222;
        push_exp(0, 32'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (bus_read_enable) ren++;
            if (bus_write_enable) wen++;
            if (c == 2) begin
                set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                bus_ready = 1'b0;
            end
        end
        checks++;
        if (wen != 1 || ren != 0) begin
            errors++;
            $display("FAIL rw_both got we=%0d re=%0d want 1 0", wen, ren);
        end
    endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clock);
            set_req(0, 32'h0000_0080, 32'h0, 4'hF, 1'b1, 1'b0);
            bus_ready = 1'b0;
            bus_read_data = 32'h7777_0000 + 32'(pass);
            push_exp(0, pass == 0 ? 32'h0 : 32'h7777_0001, pass == 0);
            for (int c = 1; c <= 10; c++) begin
                @(negedge clock);
                if (pass == 1 && c == 8) bus_ready = 1'b1;
                if (c == 9) begin
                    checks++;
                    if (port_ready !== 2'b01 || port_error !== (pass == 0 ? 2'b01 : 2'b00)) begin
                        errors++;
                        $display("FAIL timeout_pass%0d got ready=%b err=%b", pass, port_ready, port_error);
                    end
                    set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                    bus_ready = 1'b0;
                end
            end
        end
    endtask
`else
    task automatic test_no_timeout;
        int seen = 0;
        @(negedge clock);
        set_req(0, 32'h0000_0080, 32'h0, 4'hF, 1'b1, 1'b0);
        bus_ready = 1'b0;
        bus_read_data = 32'h7777_0002;
        push_exp(0, 32'h7777_0002, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (port_ready !== 2'b00) seen++;
        end
        checks++;
        if (seen != 0 || bus_read_enable !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_wait got pulses=%0d re=%b want 0 1", seen, bus_read_enable);
        end
        bus_ready = 1'b1;
        @(negedge clock);
        set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        bus_ready = 1'b0;
        repeat (3) @(negedge clock);
    endtask
`endif

    task automatic test_reset_mid;
        int n = 0;
        @(negedge clock);
        set_req(0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 1'b0);
        bus_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus_read_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_access got re=%b want 1", bus_read_enable);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable} !== '0 ||
            port_ready !== '0 || port_error !== '0 || port_read_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs addr=%h re=%b rdy=%b want 0", bus_address, bus_read_enable, port_ready);
        end
        set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        set_req(0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 1'b0);
        set_req(1, 32'h0000_0400, 32'h0, 4'hF, 1'b1, 1'b0);
        bus_ready = 1'b1;
        bus_read_data = 32'hCAFE_0001;
        push_exp(0, 32'hCAFE_0001, 1'b0);
        for (int c = 1; c <= 10 && n == 0; c++) begin
            @(negedge clock);
            if (port_ready !== 2'b00) begin
                n++;
                checks++;
                if (port_ready !== 2'b01) begin
                    errors++;
                    $display("FAIL post_reset_winner got %b want 01", port_ready);
                end
                set_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                set_req(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                bus_ready = 1'b0;
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL post_reset_done got %0d want 1", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        clock = 1'b0;
        reset = 1'b0;
        port_address = '0;
        port_write_data = '0;
        port_byte_enable = '0;
        port_read_enable = '0;
        port_write_enable = '0;
        bus_ready = 1'b0;
        bus_read_data = '0;
        test_reset;
        test_read_zero_wait;
        test_write_wait;
        test_back_to_back;
        test_read_write_both;
`ifdef BUS_ARBITER_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        test_reset_mid;
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
